// File: rtl/psram_access_arbiter_pkg.sv
// Shared types for the PSRAM access arbiter: FSM states and port-owner encoding.
package PsramArbiterTypes;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_WR   = 2'd1,
    OWNER_RD   = 2'd2
  } owner_t;

endpackage

// File: rtl/psram_access_arbiter_if.sv
// Requester and memory-side bus bundle of the PSRAM access arbiter.
interface psram_access_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              wr_rq;
  logic              wr_ack;
  logic              wr_cmd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_rq;
  logic              rd_ack;
  logic              rd_cmd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              mem_cmd_en;
  logic              mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;

  // Arbiter side
  modport slave (
    input  wr_rq, wr_cmd_en, wr_addr, wr_data, rd_rq, rd_cmd_en, rd_addr,
    output wr_ack, rd_ack, mem_cmd_en, mem_cmd, mem_addr, mem_wr_data
  );

  // Requester / memory-controller side
  modport master (
    output wr_rq, wr_cmd_en, wr_addr, wr_data, rd_rq, rd_cmd_en, rd_addr,
    input  wr_ack, rd_ack, mem_cmd_en, mem_cmd, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/psram_access_arbiter_port_mux.sv
// Registered owner-select mux driving the memory controller command/data port.
module psram_port_mux
  import PsramArbiterTypes::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  owner_t            owner,
  input  logic              write_next,
  input  logic              wr_cmd_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_cmd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              mem_cmd_en,
  output logic              mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_cmd_en  <= 1'b0;
      mem_cmd     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      // Direction tracks the state being entered so it lines up with the grant.
      mem_cmd <= write_next;
      case (owner)
        OWNER_WR: begin
          mem_cmd_en  <= wr_cmd_en;
          mem_addr    <= wr_addr;
          mem_wr_data <= wr_data;
        end
        OWNER_RD: begin
          mem_cmd_en <= rd_cmd_en;
          mem_addr   <= rd_addr;
        end
        default: mem_cmd_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/psram_access_arbiter.sv
// Reader-priority whole-transaction arbiter in front of the PSRAM controller.
// Optional writer starvation guard: define ARB_STARVATION_GUARD_EN.
module psram_access_arbiter
  import PsramArbiterTypes::*;
#(
  parameter int ADDR_W        = 21,
  parameter int DATA_W        = 32,
  parameter int HOLD_MAX      = 64,
  parameter int RD_STREAK_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_ready,
  psram_access_arbiter_if.slave  bus,
  output logic                   busy,
  output logic                   hold_timeout
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  arb_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              hold_timeout_reg;
  logic              writer_forced;
  logic              wr_ack, rd_ack, write_next;
  owner_t            cmd_owner;

  // Empty marker scope when parameters are out of their meaningful range.
  if (HOLD_MAX < 1 || RD_STREAK_MAX < 1) begin : g_param_out_of_range
  end

`ifdef ARB_STARVATION_GUARD_EN
  localparam int STREAK_W = $clog2(RD_STREAK_MAX + 1);
  logic [STREAK_W-1:0] streak_reg;

  assign writer_forced = bus.wr_rq && (streak_reg == STREAK_W'(RD_STREAK_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_reg <= '0;
    end else if (state_reg == IDLE && state_next != IDLE) begin
      if (state_next == GRANT_RD && bus.wr_rq)
        streak_reg <= streak_reg + 1'b1;
      else
        streak_reg <= '0;
    end
  end
`else
  assign writer_forced = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mem_ready) begin
          if (writer_forced)  state_next = GRANT_WR;
          else if (bus.rd_rq) state_next = GRANT_RD;
          else if (bus.wr_rq) state_next = GRANT_WR;
        end
      end
      GRANT_WR: if (!bus.wr_rq) state_next = RELEASE;
      GRANT_RD: if (!bus.rd_rq) state_next = RELEASE;
      RELEASE:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ack     = (state_reg == GRANT_WR);
    rd_ack     = (state_reg == GRANT_RD);
    busy       = (state_reg != IDLE);
    write_next = (state_next == GRANT_WR);
    // Commands issued on the owner's final (rq-dropping) cycle are not forwarded,
    // which keeps the RELEASE cycle free of memory-side strobes.
    cmd_owner = OWNER_NONE;
    if (state_reg == GRANT_WR && state_next == GRANT_WR) cmd_owner = OWNER_WR;
    if (state_reg == GRANT_RD && state_next == GRANT_RD) cmd_owner = OWNER_RD;
  end

  // Counts grant cycles including the one being entered, saturating at HOLD_MAX.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (state_next == GRANT_WR || state_next == GRANT_RD) begin
      if (state_reg != state_next)
        hold_cnt_next = HOLD_W'(1);
      else if (hold_cnt_reg != HOLD_W'(HOLD_MAX))
        hold_cnt_next = hold_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_reg     <= '0;
      hold_timeout_reg <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      if (hold_cnt_next == HOLD_W'(HOLD_MAX)) hold_timeout_reg <= 1'b1;
    end
  end

  assign hold_timeout = hold_timeout_reg;
  assign bus.wr_ack   = wr_ack;
  assign bus.rd_ack   = rd_ack;

  logic              mux_cmd_en, mux_cmd;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wr_data;

  psram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .clk         (clk),
    .reset_n     (reset_n),
    .owner       (cmd_owner),
    .write_next  (write_next),
    .wr_cmd_en   (bus.wr_cmd_en),
    .wr_addr     (bus.wr_addr),
    .wr_data     (bus.wr_data),
    .rd_cmd_en   (bus.rd_cmd_en),
    .rd_addr     (bus.rd_addr),
    .mem_cmd_en  (mux_cmd_en),
    .mem_cmd     (mux_cmd),
    .mem_addr    (mux_addr),
    .mem_wr_data (mux_wr_data)
  );

  assign bus.mem_cmd_en  = mux_cmd_en;
  assign bus.mem_cmd     = mux_cmd;
  assign bus.mem_addr    = mux_addr;
  assign bus.mem_wr_data = mux_wr_data;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed bench for psram_access_arbiter; outputs sampled on the falling edge.
module tb_psram_access_arbiter;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
`ifdef ARB_STARVATION_GUARD_EN
  localparam bit GUARD = 1'b1;
  localparam int NDEC  = 5;
`else
  localparam bit GUARD = 1'b0;
  localparam int NDEC  = 6;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic mem_ready;
  logic busy;
  logic hold_timeout;
  int   total = 0;
  int   bad   = 0;

  psram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  psram_access_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .HOLD_MAX      (64),
    .RD_STREAK_MAX (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_ready    (mem_ready),
    .bus          (bus),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    mem_ready     = 1'b0;
    bus.wr_rq     = 1'b0;
    bus.wr_cmd_en = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_rq     = 1'b0;
    bus.rd_cmd_en = 1'b0;
    bus.rd_addr   = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_rd_ack", bus.rd_ack, 0);
    chk("rst_cmd_en", bus.mem_cmd_en, 0);
    chk("rst_cmd", bus.mem_cmd, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_data", bus.mem_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", hold_timeout, 0);
    reset_n = 1'b1;

    // No grant while the controller is not ready
    bus.wr_rq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("notready_wr_ack", bus.wr_ack, 0);
    end
    mem_ready = 1'b1;
    cyc();                                    // grant cycle 1
    chk("ready_wr_ack", bus.wr_ack, 1);
    chk("ready_busy", busy, 1);
    chk("ready_mem_cmd", bus.mem_cmd, 1);
    chk("ready_cmd_en_idle", bus.mem_cmd_en, 0);
    chk("hold_gc1", hold_timeout, 0);
    bus.wr_cmd_en = 1'b1;
    bus.wr_addr   = 21'h01000;
    bus.wr_data   = 32'hA5A5_5A5A;
    cyc();                                    // grant cycle 2
    chk("wr_cmd_en", bus.mem_cmd_en, 1);
    chk("wr_cmd", bus.mem_cmd, 1);
    chk("wr_addr", bus.mem_addr, 64'h01000);
    chk("wr_data", bus.mem_wr_data, 64'hA5A5_5A5A);
    bus.wr_cmd_en = 1'b0;
    bus.rd_cmd_en = 1'b1;                     // non-owner strobe must be ignored
    bus.rd_addr   = 21'h02222;
    cyc();                                    // grant cycle 3
    chk("nonowner_cmd_en", bus.mem_cmd_en, 0);
    chk("nonowner_addr", bus.mem_addr, 64'h01000);
    bus.rd_cmd_en = 1'b0;
    repeat (60) cyc();                        // grant cycle 63
    chk("hold_gc63", hold_timeout, 0);
    chk("hold_gc63_ack", bus.wr_ack, 1);
    cyc();                                    // grant cycle 64
    chk("hold_gc64", hold_timeout, 1);
    repeat (6) cyc();                         // grant cycle 70
    bus.wr_rq = 1'b0;
    cyc();                                    // RELEASE
    chk("rel_wr_ack", bus.wr_ack, 0);
    chk("rel_busy", busy, 1);
    chk("rel_cmd", bus.mem_cmd, 0);
    chk("rel_cmd_en", bus.mem_cmd_en, 0);
    chk("rel_timeout", hold_timeout, 1);
    cyc();                                    // IDLE
    chk("idle_busy", busy, 0);
    chk("idle_timeout", hold_timeout, 1);

    // Simultaneous requests: reader first, writer after a 2-cycle gap
    bus.rd_rq = 1'b1;
    bus.wr_rq = 1'b1;
    cyc();
    chk("both_rd_ack", bus.rd_ack, 1);
    chk("both_wr_ack", bus.wr_ack, 0);
    chk("both_cmd", bus.mem_cmd, 0);
    bus.rd_cmd_en = 1'b1;
    bus.rd_addr   = 21'h0ABCD;
    cyc();
    chk("rd_cmd_en", bus.mem_cmd_en, 1);
    chk("rd_cmd", bus.mem_cmd, 0);
    chk("rd_addr", bus.mem_addr, 64'h0ABCD);
    bus.rd_cmd_en = 1'b0;
    bus.rd_rq     = 1'b0;
    cyc();
    chk("gap_rel_rd_ack", bus.rd_ack, 0);
    chk("gap_rel_wr_ack", bus.wr_ack, 0);
    chk("gap_rel_busy", busy, 1);
    cyc();
    chk("gap_idle_wr_ack", bus.wr_ack, 0);
    chk("gap_idle_busy", busy, 0);
    cyc();
    chk("gap_wr_ack", bus.wr_ack, 1);
    chk("gap_wr_cmd", bus.mem_cmd, 1);

    // Asynchronous reset in the middle of a write grant
    bus.wr_cmd_en = 1'b1;
    bus.wr_addr   = 21'h1FFFFF;
    bus.wr_data   = 32'hFFFF_FFFF;
    cyc();
    chk("maxaddr", bus.mem_addr, 64'h1FFFFF);
    chk("maxaddr_cmd_en", bus.mem_cmd_en, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_wr_ack", bus.wr_ack, 0);
    chk("arst_cmd_en", bus.mem_cmd_en, 0);
    chk("arst_cmd", bus.mem_cmd, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_data", bus.mem_wr_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_timeout", hold_timeout, 0);
    bus.wr_cmd_en = 1'b0;
    bus.wr_rq     = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_busy", busy, 0);

    // Continuous reader re-requests while the writer waits
    bus.rd_rq = 1'b1;
    bus.wr_rq = 1'b1;
    for (int k = 1; k <= NDEC; k++) begin
      automatic bit exp_wr = GUARD && (k == 5);
      cyc();
      chk($sformatf("streak%0d_rd_ack", k), bus.rd_ack, !exp_wr);
      chk($sformatf("streak%0d_wr_ack", k), bus.wr_ack, exp_wr);
      if (!exp_wr) begin
        bus.rd_rq = 1'b0;
        cyc();
        bus.rd_rq = 1'b1;
        cyc();
      end
    end
    bus.rd_rq = 1'b0;
    bus.wr_rq = 1'b0;
    repeat (3) cyc();
    chk("streak_idle", busy, 0);

    // Request dropped in the cycle the grant appears: one grant cycle, then RELEASE
    bus.rd_rq = 1'b1;
    cyc();
    chk("short_rd_ack", bus.rd_ack, 1);
    bus.rd_rq = 1'b0;
    cyc();
    chk("short_rel_ack", bus.rd_ack, 0);
    chk("short_rel_busy", busy, 1);
    cyc();
    chk("short_idle", busy, 0);

    // mem_ready falling mid-grant keeps the grant; new grants blocked
    bus.rd_rq = 1'b1;
    cyc();
    chk("mr_rd_ack", bus.rd_ack, 1);
    mem_ready = 1'b0;
    repeat (3) cyc();
    chk("mr_hold_ack", bus.rd_ack, 1);
    bus.rd_rq = 1'b0;
    bus.wr_rq = 1'b1;
    repeat (4) cyc();
    chk("mr_block_wr", bus.wr_ack, 0);
    chk("mr_block_busy", busy, 0);
    bus.wr_rq = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
